encoder_speed_meter: RTL
========================

ENCODER_SPEED_METER -- requirements
Module: encoder_speed_meter

Interface
REQ-001 Parameter GATE_CYCLES, default 10000: speed-measurement window length in clk cycles (>=2).
REQ-002 Parameter FILTER_LEN, default 3: consecutive stable synchronized samples needed to accept an encoder level (>=1).
REQ-003 Parameter CNT_W, default 16: width of position and speed outputs.
REQ-004 clk  input  1  single system clock; all state on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 encoder_a  input  1  quadrature channel A, asynchronous to clk.
REQ-007 encoder_b  input  1  quadrature channel B, asynchronous to clk.
REQ-008 clear  input  1  synchronous clear of position, accumulator, window, speed, error.
REQ-009 position  output  CNT_W  signed two's-complement quadrature count.
REQ-010 speed  output  CNT_W  signed counts accumulated over the last completed window.
REQ-011 speed_valid  output  1  one-cycle pulse when speed is updated.
REQ-012 direction  output  1  1 = last step forward, 0 = last step reverse.
REQ-013 quad_error  output  1  sticky flag, illegal transition seen.

Function
REQ-014 Each channel SHALL pass a 2-flop synchronizer, then a filter that adopts the synchronized level only after FILTER_LEN consecutive equal samples differing from the current filtered level.
REQ-015 Decoder SHALL compare previous and current filtered {A,B} every cycle; forward sequence 00->01->11->10->00 = +1, reverse = -1, no change = 0.
REQ-016 Both bits changing in one cycle SHALL produce step 0 and set quad_error; quad_error stays set until clear or rst.
REQ-017 A raw input edge held stable SHALL update position exactly FILTER_LEN+3 clk edges after the first edge sampling the new level.
REQ-018 position SHALL wrap modulo 2^CNT_W (0x7FFF +1 -> 0x8000; 0x0000 -1 -> 0xFFFF).
REQ-019 direction SHALL update on every nonzero step and hold on zero steps.
REQ-020 Window counter SHALL run 0..GATE_CYCLES-1 continuously and wrap; accumulator adds each step with saturation at +(2^(CNT_W-1)-1) / -(2^(CNT_W-1)).
REQ-021 In the cycle the window counter is GATE_CYCLES-1, speed SHALL load accumulator plus that cycle's step (saturated), accumulator SHALL reset to 0, speed_valid SHALL assert for that one cycle (visible next edge).
REQ-022 clear SHALL take priority over a simultaneous step or window end: position, accumulator, window counter, speed, quad_error to 0; speed_valid 0 that cycle; synchronizer/filter state untouched.
REQ-023 First speed_valid after reset or clear SHALL occur exactly GATE_CYCLES cycles after rst deassertion / clear cycle.

Reset
REQ-024 rst SHALL asynchronously force position=0, speed=0, speed_valid=0, direction=0, quad_error=0, window counter=0, accumulator=0.
REQ-025 Synchronizer and filter flops SHALL reset to 0 and the decoder previous-state to 00, so a post-reset input of 00 causes no step.
REQ-026 rst asserted mid-window SHALL discard the partial window with no speed_valid.

Structure
REQ-027 Package enc_pkg SHALL hold step encoding (STEP_NONE, STEP_FWD, STEP_REV), the forward-sequence transition table, and default parameter constants.
REQ-028 Sub-module enc_input_filter (synchronizer + stability filter, one channel) SHALL be instantiated once per channel; decoder, position, and speed logic reside in encoder_speed_meter.

Verification
REQ-029 Reset, drive 8 forward quadrature steps 20 cycles apart -> position=8, direction=1, quad_error=0.
REQ-030 Preload position near 0x7FFF via 32767 forward steps, one more forward step -> position=0x8000; then 1 reverse -> 0x7FFF, direction=0.
REQ-031 Glitch on A of FILTER_LEN-1 cycles (default 2) -> position unchanged; pulse of FILTER_LEN+? stable cycles -> one step after FILTER_LEN+3 cycles.
REQ-032 GATE_CYCLES=100, 25 forward steps per window -> speed_valid every 100 cycles, speed=25; reverse at same rate -> speed=-25 (0xFFE7).
REQ-033 Drive 00->11 directly -> quad_error=1, position unchanged; assert clear -> quad_error=0, position=0, speed=0, next speed_valid 100 cycles later.
REQ-034 Step landing in window's final cycle simultaneous with clear -> all counters 0, no speed_valid; rst asserted mid-window -> outputs 0 asynchronously, no pulse.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared definitions for the quadrature encoder speed meter.
package enc_pkg;

  typedef enum logic [1:0] {
    STEP_NONE = 2'b00,
    STEP_FWD  = 2'b01,
    STEP_REV  = 2'b10
  } step_t;

  localparam int unsigned DEF_GATE_CYCLES = 10000;
  localparam int unsigned DEF_FILTER_LEN  = 3;
  localparam int unsigned DEF_CNT_W       = 16;

  // Forward successor of each {A,B} state: 00->01->11->10->00
  localparam logic [1:0] FWD_NEXT [4] = '{2'b01, 2'b11, 2'b00, 2'b10};

  // Double-bit changes match neither direction and decode as STEP_NONE.
  function automatic step_t decode_step(input logic [1:0] prev, input logic [1:0] cur);
    if (FWD_NEXT[prev] == cur) return STEP_FWD;
    if (FWD_NEXT[cur] == prev) return STEP_REV;
    return STEP_NONE;
  endfunction

endpackage

// File: rtl/enc_input_filter.sv
// One encoder channel: 2-flop synchronizer followed by a stability filter.
module enc_input_filter import enc_pkg::*; #(
  parameter int unsigned FILTER_LEN = DEF_FILTER_LEN
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level
);

  localparam int unsigned CW = $clog2(FILTER_LEN + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic [CW-1:0] r_cnt;

  // Bring the asynchronous input into the clk domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Adopt a new level only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else if (r_sync2 != r_level) begin
      if (r_cnt == CW'(FILTER_LEN - 1)) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end else begin
      r_cnt <= '0;
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/encoder_speed_meter.sv
// Quadrature decoder with position counter and gated speed measurement.
module encoder_speed_meter import enc_pkg::*; #(
  parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int unsigned FILTER_LEN  = DEF_FILTER_LEN,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             encoder_a,
  input  logic             encoder_b,
  input  logic             clear,
  output logic [CNT_W-1:0] position,
  output logic [CNT_W-1:0] speed,
  output logic             speed_valid,
  output logic             direction,
  output logic             quad_error
);

  localparam int unsigned WIN_W = $clog2(GATE_CYCLES);

  logic             w_a;
  logic             w_b;
  logic [1:0]       w_cur;
  logic [1:0]       r_prev;
  step_t            w_step;
  logic             w_illegal;
  logic [CNT_W:0]   w_delta;
  logic [CNT_W:0]   w_sum;
  logic [CNT_W-1:0] w_acc_sat;
  logic             w_win_end;

  logic [CNT_W-1:0] r_pos;
  logic [CNT_W-1:0] r_acc;
  logic [CNT_W-1:0] r_speed;
  logic [WIN_W-1:0] r_win;
  logic             r_sv;
  logic             r_dir;
  logic             r_qerr;

  enc_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk(clk), .rst(rst), .i_raw(encoder_a), .o_level(w_a)
  );

  enc_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk(clk), .rst(rst), .i_raw(encoder_b), .o_level(w_b)
  );

  // Decode step, illegal transition and saturated accumulator update
  always_comb begin
    w_cur     = {w_a, w_b};
    w_step    = decode_step(r_prev, w_cur);
    w_illegal = ((r_prev ^ w_cur) == 2'b11);
    case (w_step)
      STEP_FWD: w_delta = (CNT_W + 1)'(1);
      STEP_REV: w_delta = '1;
      default:  w_delta = '0;
    endcase
    // One guard bit; disagreeing top bits flag overflow in that direction
    w_sum = {r_acc[CNT_W-1], r_acc} + w_delta;
    if (!w_sum[CNT_W] && w_sum[CNT_W-1])
      w_acc_sat = {1'b0, {(CNT_W - 1){1'b1}}};
    else if (w_sum[CNT_W] && !w_sum[CNT_W-1])
      w_acc_sat = {1'b1, {(CNT_W - 1){1'b0}}};
    else
      w_acc_sat = w_sum[CNT_W-1:0];
    w_win_end = (r_win == WIN_W'(GATE_CYCLES - 1));
  end

  // Remember last filtered state for the decoder
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_prev <= 2'b00;
    else     r_prev <= w_cur;
  end

  // Position, direction and sticky error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pos  <= '0;
      r_dir  <= 1'b0;
      r_qerr <= 1'b0;
    end else if (clear) begin
      r_pos  <= '0;
      r_qerr <= 1'b0;
    end else begin
      r_pos <= r_pos + w_delta[CNT_W-1:0];
      if (w_step != STEP_NONE) r_dir <= (w_step == STEP_FWD);
      if (w_illegal)           r_qerr <= 1'b1;
    end
  end

  // Free-running gate window; publish accumulated count at window end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win   <= '0;
      r_acc   <= '0;
      r_speed <= '0;
      r_sv    <= 1'b0;
    end else if (clear) begin
      r_win   <= '0;
      r_acc   <= '0;
      r_speed <= '0;
      r_sv    <= 1'b0;
    end else if (w_win_end) begin
      r_win   <= '0;
      r_acc   <= '0;
      r_speed <= w_acc_sat;
      r_sv    <= 1'b1;
    end else begin
      r_win   <= r_win + WIN_W'(1);
      r_acc   <= w_acc_sat;
      r_sv    <= 1'b0;
    end
  end

  assign position    = r_pos;
  assign speed       = r_speed;
  assign speed_valid = r_sv;
  assign direction   = r_dir;
  assign quad_error  = r_qerr;

endmodule
